// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Bits needed to hold values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Counts enabled cycles 0..PRESCALE-1; tick marks the last cycle of each window.
module prescaler_tick
   import counter_pkg::*;
#(
   parameter int PRESCALE = 2
) (
   input  logic clock,
   input  logic clear,
   input  logic enable,
   input  logic restart,
   output logic tick
);

   localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clock or posedge clear) begin
      if (clear)        cnt <= '0;
      else if (restart) cnt <= '0;
      else if (enable)  cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with programmable limit, load, wrap/saturate
// modes, optional prescaler, wrap pulse and sticky overflow.
module updown_counter_n
   import counter_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   input  logic             saturate,
   input  logic             clear_ovf,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   logic             tick;
   logic             step;
   logic             hit;
   logic [WIDTH-1:0] q_nxt;

   generate
      if (PRESCALE > 1) begin : g_pre
         prescaler_tick #(.PRESCALE(PRESCALE)) u_pre (
            .clock   (clock),
            .clear   (clear),
            .enable  (enable),
            .restart (load),
            .tick    (tick)
         );
      end else begin : g_nopre
         assign tick = 1'b1;
      end
   endgenerate

   assign step = enable & tick;

   // The terminal condition for a step is exactly tc; Q above limit counts as terminal going up.
   assign tc  = (up == DIR_UP) ? (Q >= limit) : (Q == '0);
   assign hit = ~load & step & tc;

   always_comb begin
      q_nxt = Q;
      if (load)
         q_nxt = load_value;
      else if (step) begin
         if (!tc)
            q_nxt = (up == DIR_UP) ? Q + 1'b1 : Q - 1'b1;
         else if (up == DIR_UP)
            q_nxt = (saturate == MODE_SAT) ? limit : '0;
         else
            q_nxt = (saturate == MODE_WRAP) ? limit : '0;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         Q    <= '0;
         wrap <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         Q    <= q_nxt;
         wrap <= hit;
         ovf  <= hit | (ovf & ~clear_ovf);
      end
   end

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n (PRESCALE=1 and PRESCALE=3 instances share stimulus).
module tb_updown_counter_n;

   logic       clock = 1'b0;
   logic       clear, enable, up, load, saturate, clear_ovf;
   logic [3:0] load_value, limit;
   logic [3:0] q1, q3;
   logic       tc1, tc3, w1, w3, o1, o3;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string      tag;
      bit         sel;
      logic [3:0] q;
      logic       w;
      logic       o;
   } exp_t;

   exp_t sbq[$];

   bit en_pat [7] = '{1, 1, 0, 1, 1, 1, 1};
   int qpat   [7] = '{0, 0, 0, 1, 1, 1, 2};

   always #5 clock = ~clock;

   updown_counter_n #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .limit(limit), .saturate(saturate),
      .clear_ovf(clear_ovf), .Q(q1), .tc(tc1), .wrap(w1), .ovf(o1)
   );

   updown_counter_n #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
      .load_value(load_value), .limit(limit), .saturate(saturate),
      .clear_ovf(clear_ovf), .Q(q3), .tc(tc3), .wrap(w3), .ovf(o3)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // Push the expectation for the coming edge, then pop and compare after it.
   task automatic cyc(input string tag, input bit sel, input logic [3:0] q,
                      input logic w, input logic o);
      exp_t e;
      e.tag = tag; e.sel = sel; e.q = q; e.w = w; e.o = o;
      sbq.push_back(e);
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      if (e.sel) begin
         chk({e.tag, ".q"}, 32'(q3), 32'(e.q));
         chk({e.tag, ".wrap"}, 32'(w3), 32'(e.w));
         chk({e.tag, ".ovf"}, 32'(o3), 32'(e.o));
      end else begin
         chk({e.tag, ".q"}, 32'(q1), 32'(e.q));
         chk({e.tag, ".wrap"}, 32'(w1), 32'(e.w));
         chk({e.tag, ".ovf"}, 32'(o1), 32'(e.o));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      clear = 1'b1; enable = 1'b0; up = 1'b1; load = 1'b0; saturate = 1'b0;
      clear_ovf = 1'b0; load_value = 4'd0; limit = 4'd15;
      #12;
      chk("rst.q1", 32'(q1), 0);
      chk("rst.w1", 32'(w1), 0);
      chk("rst.o1", 32'(o1), 0);
      chk("rst.q3", 32'(q3), 0);
      clear = 1'b0;

      // Basic up count through wrap
      enable = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         cyc("cnt", 0, 4'(i % 16), i == 16, i >= 16);
         if (i == 14) chk("tc_lo", 32'(tc1), 0);
         if (i == 15) chk("tc_hi", 32'(tc1), 1);
      end

      // Down with saturation
      load = 1'b1; load_value = 4'd2; enable = 1'b0;
      cyc("ld2", 0, 4'd2, 0, 1);
      load = 1'b0; up = 1'b0; saturate = 1'b1; enable = 1'b1;
      cyc("dn1", 0, 4'd1, 0, 1);
      cyc("dn0", 0, 4'd0, 0, 1);
      chk("tc_dn0", 32'(tc1), 1);
      cyc("sat0a", 0, 4'd0, 1, 1);
      cyc("sat0b", 0, 4'd0, 1, 1);
      enable = 1'b0; clear_ovf = 1'b1;
      cyc("covf", 0, 4'd0, 0, 0);
      clear_ovf = 1'b0;

      // Programmable limit with out-of-range load
      limit = 4'd9; saturate = 1'b0; up = 1'b1; enable = 1'b1;
      load = 1'b1; load_value = 4'd12;
      cyc("ld12", 0, 4'd12, 0, 0);
      chk("tc_oor", 32'(tc1), 1);
      load = 1'b0;
      cyc("oor_up", 0, 4'd0, 1, 1);
      load = 1'b1;
      cyc("ld12b", 0, 4'd12, 0, 1);
      load = 1'b0; saturate = 1'b1;
      cyc("oor_sat", 0, 4'd9, 1, 1);
      load = 1'b1;
      cyc("ld12c", 0, 4'd12, 0, 1);
      load = 1'b0; up = 1'b0;
      cyc("oor_dn", 0, 4'd11, 0, 1);

      // Load beats a terminal step; set beats clear_ovf
      up = 1'b1; saturate = 1'b0; load = 1'b1; load_value = 4'd9;
      cyc("ld_pri", 0, 4'd9, 0, 1);
      load = 1'b0; clear_ovf = 1'b1;
      cyc("wrap_covf", 0, 4'd0, 1, 1);
      enable = 1'b0;
      cyc("covf2", 0, 4'd0, 0, 0);
      clear_ovf = 1'b0;

      // limit = 0: every step terminates
      limit = 4'd0; enable = 1'b1;
      cyc("l0_up", 0, 4'd0, 1, 1);
      up = 1'b0;
      cyc("l0_dn", 0, 4'd0, 1, 1);
      saturate = 1'b1;
      cyc("l0_sat", 0, 4'd0, 1, 1);
      chk("tc_l0", 32'(tc1), 1);

      // Async clear takes effect between edges
      clear = 1'b1;
      #1;
      chk("aclr.q1", 32'(q1), 0);
      chk("aclr.w1", 32'(w1), 0);
      chk("aclr.o1", 32'(o1), 0);
      @(posedge clock);
      #1;
      clear = 1'b0;

      // Prescaler window of 3 enabled cycles
      limit = 4'd15; up = 1'b1; saturate = 1'b0;
      for (int i = 0; i < 7; i++) begin
         enable = en_pat[i];
         cyc("pre", 1, 4'(qpat[i]), 0, 0);
      end
      enable = 1'b1;
      cyc("pre_mid", 1, 4'd2, 0, 0);
      load = 1'b1; load_value = 4'd5;
      cyc("pre_ld", 1, 4'd5, 0, 0);
      load = 1'b0;
      cyc("pre_r1", 1, 4'd5, 0, 0);
      cyc("pre_r2", 1, 4'd5, 0, 0);
      cyc("pre_r3", 1, 4'd6, 0, 0);

      // Clear mid-window discards the pending prescale count
      load = 1'b1; load_value = 4'd7;
      cyc("ld7", 1, 4'd7, 0, 0);
      load = 1'b0;
      cyc("p1", 1, 4'd7, 0, 0);
      #2;
      clear = 1'b1;
      #1;
      chk("aclr.q3", 32'(q3), 0);
      chk("aclr.o3", 32'(o3), 0);
      @(posedge clock);
      #1;
      clear = 1'b0;
      cyc("rc1", 1, 4'd0, 0, 0);
      cyc("rc2", 1, 4'd0, 0, 0);
      cyc("rc3", 1, 4'd1, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
